// File: rtl/ccip_avmm_pkg.sv
// Shared CCI-P / Avalon-MM helpers: address layout constants and the
// multi-CL chunk-size rule used by both the write and read re-chunkers.
package ccip_avmm_pkg;

  // Address bit 48 carries the write-fence flag; bits 47:0 are the host byte address.
  localparam int CCIP_AVMM_FENCE_BIT      = 48;
  // Largest multi-CL request CCI-P accepts.
  localparam int CCIP_AVMM_MAX_CCIP_BURST = 4;
  // One cache line is 64 bytes.
  localparam int CCIP_AVMM_CL_OFFSET_W    = 6;
  // Cache-line address width (bits 47:6 of the byte address).
  localparam int CCIP_AVMM_CL_ADDR_W      = CCIP_AVMM_FENCE_BIT - CCIP_AVMM_CL_OFFSET_W;

  typedef logic [CCIP_AVMM_CL_ADDR_W-1:0] ccip_cl_addr_t;
  typedef logic [2:0]                     ccip_chunk_size_t;

  // Pick the largest naturally aligned CCI-P burst (4, 2 or 1 lines) that
  // starts at a line whose two low address bits are cl_addr_lsbs and does not
  // run past the beats still owed by the current upstream burst.
  function automatic ccip_chunk_size_t ccip_chunk_size(input logic [1:0]  cl_addr_lsbs,
                                                       input logic [15:0] remaining);
    ccip_chunk_size_t size;
    size = 3'd1;
    if (remaining >= 16'(CCIP_AVMM_MAX_CCIP_BURST) && cl_addr_lsbs == 2'b00) begin
      size = 3'd4;
    end else if (remaining >= 16'd2 && !cl_addr_lsbs[0]) begin
      size = 3'd2;
    end
    return size;
  endfunction

endpackage

// File: rtl/avmm_skid_buffer.sv
// Two-entry skid buffer with a fully registered output and a registered
// ready. The output register is entry one; the skid register catches the one
// beat that can arrive in the cycle after the consumer stalls.
//
// Handshake: a transfer happens on a clock edge where valid and ready are both
// high. The producer side may only count a beat as taken when in_valid &
// in_ready; out_valid never depends combinationally on out_ready.
module avmm_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         skid_full
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         push;

  assign in_ready  = ~skid_valid;
  assign push      = in_valid & ~skid_valid;
  assign skid_full = skid_valid;

  // Refill the output register from the skid entry first (oldest beat), else
  // from the input; park the input in the skid entry while the output stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= push;
        if (push) begin
          out_data <= in_data;
        end
      end
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/avmm_ccip_wr_burst_aligner.sv
// Avalon-MM write-burst re-chunker. Splits arbitrary upstream write bursts
// into naturally aligned 1/2/4-line bursts so the CCI-P bridge downstream can
// issue multi-CL writes. One beat per cycle, one cycle from acceptance to
// m_write. Only the first chunk of a split burst carries the fence flag.
module avmm_ccip_wr_burst_aligner
  import ccip_avmm_pkg::*;
#(
  parameter int DATA_W      = 512,
  parameter int ADDR_W      = 49,
  parameter int IN_BURST_W  = 7,
  parameter int OUT_BURST_W = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_write,
  input  logic [ADDR_W-1:0]      s_address,
  input  logic [IN_BURST_W-1:0]  s_burstcount,
  input  logic [DATA_W-1:0]      s_writedata,
  output logic                   s_waitrequest,
  output logic                   m_write,
  output logic [ADDR_W-1:0]      m_address,
  output logic [OUT_BURST_W-1:0] m_burstcount,
  output logic [DATA_W-1:0]      m_writedata,
  input  logic                   m_waitrequest,
  output logic                   idle,
  output logic                   dbg_in_state
);

  localparam int CL_W  = CCIP_AVMM_CL_ADDR_W;
  localparam int PAY_W = ADDR_W + OUT_BURST_W + DATA_W;

  // Input FSM: IDLE expects the first beat of a burst, ACTIVE counts the rest.
  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACTIVE = 1'b1;

  logic                  state_q;
  ccip_cl_addr_t         cl_addr_q;
  logic [IN_BURST_W-1:0] remaining_q;
  logic [2:0]            beats_left_q;
  logic [ADDR_W-1:0]     chunk_addr_q;
  ccip_chunk_size_t      chunk_size_q;

  logic                  in_accept;
  logic                  buf_ready;
  logic                  skid_full;
  ccip_cl_addr_t         cur_cl;
  logic [IN_BURST_W-1:0] cur_rem;
  logic                  start_chunk;
  logic                  start_fence;
  ccip_chunk_size_t      sel_size;
  logic [ADDR_W-1:0]     beat_addr;
  ccip_chunk_size_t      beat_size;
  logic [2:0]            beat_left;
  logic [PAY_W-1:0]      buf_in;
  logic [PAY_W-1:0]      buf_out;

  // Byte offset within a line carries no information for line-sized beats.
  logic unused_addr_bits;
  assign unused_addr_bits = ^s_address[CCIP_AVMM_CL_OFFSET_W-1:0];

  // Upstream stall follows the skid entry; held high while reset is asserted.
  assign s_waitrequest = skid_full | reset;
  assign in_accept     = s_write & buf_ready & ~reset;

  // Resolve the line address, beats owed and chunk fields for the beat being
  // offered; a first beat takes its address and length from the bus.
  always_comb begin
    cur_cl      = cl_addr_q;
    cur_rem     = remaining_q;
    start_chunk = (beats_left_q == 3'd0);
    start_fence = 1'b0;
    if (state_q == ST_IDLE) begin
      cur_cl      = s_address[CCIP_AVMM_FENCE_BIT-1:CCIP_AVMM_CL_OFFSET_W];
      cur_rem     = (s_burstcount == '0) ? IN_BURST_W'(1) : s_burstcount;
      start_chunk = 1'b1;
      start_fence = s_address[CCIP_AVMM_FENCE_BIT];
    end
    sel_size = ccip_chunk_size(cur_cl[1:0], 16'(cur_rem));
    if (start_chunk) begin
      beat_addr = ADDR_W'({start_fence, cur_cl, {CCIP_AVMM_CL_OFFSET_W{1'b0}}});
      beat_size = sel_size;
      beat_left = sel_size - 3'd1;
    end else begin
      beat_addr = chunk_addr_q;
      beat_size = chunk_size_q;
      beat_left = beats_left_q - 3'd1;
    end
  end

  // Advance the line address and burst/chunk counters on each accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cl_addr_q    <= '0;
      remaining_q  <= '0;
      beats_left_q <= '0;
      chunk_addr_q <= '0;
      chunk_size_q <= '0;
    end else if (in_accept) begin
      state_q      <= (cur_rem == IN_BURST_W'(1)) ? ST_IDLE : ST_ACTIVE;
      cl_addr_q    <= cur_cl + CL_W'(1);
      remaining_q  <= cur_rem - IN_BURST_W'(1);
      beats_left_q <= beat_left;
      chunk_addr_q <= beat_addr;
      chunk_size_q <= beat_size;
    end
  end

  assign buf_in = {beat_addr, OUT_BURST_W'(beat_size), s_writedata};

  avmm_skid_buffer #(
    .W (PAY_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s_write & ~reset),
    .in_ready  (buf_ready),
    .in_data   (buf_in),
    .out_valid (m_write),
    .out_ready (~m_waitrequest),
    .out_data  (buf_out),
    .skid_full (skid_full)
  );

  assign m_address    = buf_out[PAY_W-1 -: ADDR_W];
  assign m_burstcount = buf_out[DATA_W +: OUT_BURST_W];
  assign m_writedata  = buf_out[DATA_W-1:0];

  assign idle         = (state_q == ST_IDLE) & ~m_write & ~skid_full;
  assign dbg_in_state = state_q;

  // A zero-length burst is a master bug; it is handled as a single beat.
  a_no_zero_burst : assert property (@(posedge clk) disable iff (reset)
    (in_accept && state_q == ST_IDLE) |-> (s_burstcount != '0));

endmodule

// File: tb/tb_avmm_ccip_wr_burst_aligner.sv
// Bench for avmm_ccip_wr_burst_aligner: directed bursts with hand-written
// expected chunks, then random bursts against a chunking reference model.
`timescale 1ns/1ps
module tb_avmm_ccip_wr_burst_aligner;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         s_write = 1'b0;
  logic [48:0]  s_address = '0;
  logic [6:0]   s_burstcount = '0;
  logic [511:0] s_writedata = '0;
  logic         s_waitrequest;
  logic         m_write;
  logic [48:0]  m_address;
  logic [2:0]   m_burstcount;
  logic [511:0] m_writedata;
  logic         m_waitrequest = 1'b0;
  logic         idle;
  logic         dbg_in_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  avmm_ccip_wr_burst_aligner dut (
    .clk           (clk),
    .reset         (reset),
    .s_write       (s_write),
    .s_address     (s_address),
    .s_burstcount  (s_burstcount),
    .s_writedata   (s_writedata),
    .s_waitrequest (s_waitrequest),
    .m_write       (m_write),
    .m_address     (m_address),
    .m_burstcount  (m_burstcount),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest),
    .idle          (idle),
    .dbg_in_state  (dbg_in_state)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [48:0]  exp_addr_q[$];
  logic [2:0]   exp_cnt_q[$];
  logic [511:0] exp_data_q[$];
  int           acc_cyc_q[$];
  int           out_cyc_q[$];
  logic [511:0] burst_data[128];
  bit           mon_en = 1'b0;
  bit           wr_rand = 1'b0;
  int           mon_bib = 0;
  logic [48:0]  hold_addr;
  logic [2:0]   hold_cnt;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Downstream backpressure: changes just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    m_waitrequest = wr_rand ? ($urandom_range(0, 1) == 1) : 1'b0;
  end

  // Monitor: every beat the sink takes is checked against the expected queue
  // and against the chunk legality rules (size 1/2/4, aligned, fields stable).
  always @(negedge clk) begin
    if (mon_en && !reset && m_write && !m_waitrequest) begin
      logic [1:0] mask;
      out_cyc_q.push_back(cyc);
      if (mon_bib == 0) begin
        hold_addr = m_address;
        hold_cnt  = m_burstcount;
        mask      = 2'(m_burstcount - 3'd1);
        check("legal_count", (m_burstcount == 3'd1 || m_burstcount == 3'd2 || m_burstcount == 3'd4), 1);
        check("aligned", m_address[7:6] & mask, 0);
      end else begin
        check("addr_stable", m_address, hold_addr);
        check("count_stable", m_burstcount, hold_cnt);
      end
      mon_bib++;
      if (mon_bib >= int'(hold_cnt)) mon_bib = 0;
      tests++;
      assert (exp_addr_q.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_beat observed=%0h expected=none", m_address);
      end
      if (exp_addr_q.size() > 0) begin
        check("beat_addr", m_address, exp_addr_q.pop_front());
        check("beat_count", m_burstcount, exp_cnt_q.pop_front());
        check("beat_data", m_writedata, exp_data_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [48:0] rand49();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[48:0];
  endfunction

  task automatic gen_data(input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 16; j++) burst_data[i][j*32 +: 32] = $urandom();
  endtask

  task automatic exp_chunk(input logic [48:0] addr, input int size, input int idx);
    for (int k = 0; k < size; k++) begin
      exp_addr_q.push_back(addr);
      exp_cnt_q.push_back(3'(size));
      exp_data_q.push_back(burst_data[idx + k]);
    end
  endtask

  // Reference: greedy largest aligned chunk that fits, fence on first only.
  task automatic model_push(input logic [48:0] addr, input int n, input int idx);
    logic [41:0] cl;
    int          rem;
    int          sz;
    bit          f;
    cl = addr[47:6];
    rem = n;
    f = addr[48];
    while (rem > 0) begin
      if (rem >= 4 && cl % 4 == 0) sz = 4;
      else if (rem >= 2 && cl % 2 == 0) sz = 2;
      else sz = 1;
      exp_chunk({f, cl, 6'b0}, sz, idx);
      idx += sz;
      cl  += 42'(sz);
      rem -= sz;
      f = 1'b0;
    end
  endtask

  task automatic drive_beat(input logic [48:0] addr, input int cnt, input logic [511:0] data, input bit first);
    int waited;
    bit w;
    waited = 0;
    @(negedge clk);
    s_write      = 1'b1;
    s_address    = first ? addr : rand49();
    s_burstcount = first ? 7'(cnt) : 7'($urandom());
    s_writedata  = data;
    forever begin
      w = s_waitrequest;
      @(posedge clk);
      if (!w || waited > 2000) break;
      waited++;
      @(negedge clk);
    end
    check("beat_accepted", w, 0);
    #1 acc_cyc_q.push_back(cyc);
  endtask

  task automatic drive_burst(input logic [48:0] addr, input int n, input int idx);
    for (int b = 0; b < n; b++) drive_beat(addr, n, burst_data[idx + b], b == 0);
  endtask

  task automatic end_input();
    @(negedge clk);
    s_write = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_addr_q.size() != 0 || !idle) && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_left"}, exp_addr_q.size(), 0);
    check({tag, "_idle"}, idle, 1);
  endtask

  task automatic clear_logs();
    acc_cyc_q.delete();
    out_cyc_q.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [48:0] a;
    logic [41:0] cl;
    int          n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_write", m_write, 0);
    check("rst_s_waitrequest", s_waitrequest, 1);
    check("rst_idle", idle, 1);
    check("rst_m_address", m_address, 0);
    check("rst_m_burstcount", m_burstcount, 0);
    check("rst_state", dbg_in_state, 0);
    reset = 1'b0;
    #1 check("post_rst_waitrequest", s_waitrequest, 0);
    mon_en = 1'b1;

    // 1: aligned 4-beat burst passes as one 4CL burst, 1-cycle latency.
    gen_data(4);
    clear_logs();
    exp_chunk(49'h1000, 4, 0);
    drive_burst(49'h1000, 4, 0);
    end_input();
    wait_drain("t1");
    check("t1_out_beats", out_cyc_q.size(), 4);
    for (int i = 0; i < 4; i++) check("t1_out_cycle", out_cyc_q[i], acc_cyc_q[0] + i);

    // 2: misaligned 4-beat burst splits 1/2/1.
    gen_data(4);
    exp_chunk(49'h1040, 1, 0);
    exp_chunk(49'h1080, 2, 1);
    exp_chunk(49'h1100, 1, 3);
    drive_burst(49'h1040, 4, 0);
    end_input();
    wait_drain("t2");

    // 3: 3-beat then back-to-back single, no input bubble.
    gen_data(4);
    clear_logs();
    exp_chunk(49'h1000, 2, 0);
    exp_chunk(49'h1080, 1, 2);
    exp_chunk(49'h2000, 1, 3);
    drive_burst(49'h1000, 3, 0);
    drive_burst(49'h2000, 1, 3);
    end_input();
    wait_drain("t3");
    for (int i = 1; i < 4; i++) check("t3_acc_cycle", acc_cyc_q[i], acc_cyc_q[0] + i);
    check("t3_out_beats", out_cyc_q.size(), 4);

    // 4: maximum-length burst from an odd line.
    gen_data(64);
    exp_chunk(49'h1040, 1, 0);
    exp_chunk(49'h1080, 2, 1);
    for (int i = 0; i < 15; i++) exp_chunk(49'h1100 + 49'(i * 'h100), 4, 3 + 4 * i);
    exp_chunk(49'h2000, 1, 63);
    check("t4_expected_beats", exp_addr_q.size(), 64);
    drive_burst(49'h1040, 64, 0);
    end_input();
    wait_drain("t4");

    // 5: fence bit only on the first chunk.
    gen_data(4);
    exp_chunk(49'h1_0000_0000_1040, 1, 0);
    exp_chunk(49'h0_0000_0000_1080, 2, 1);
    exp_chunk(49'h0_0000_0000_1100, 1, 3);
    drive_burst(49'h1_0000_0000_1040, 4, 0);
    end_input();
    wait_drain("t5");

    // 5b: line address wraps modulo 2^42.
    gen_data(4);
    exp_chunk(49'h0_FFFF_FFFF_FFC0, 1, 0);
    exp_chunk(49'h0_0000_0000_0000, 2, 1);
    drive_burst(49'h0_FFFF_FFFF_FFC0, 3, 0);
    end_input();
    wait_drain("t5b");

    // 6: random bursts under random downstream backpressure.
    wr_rand = 1'b1;
    for (int b = 0; b < 1000; b++) begin
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 64) : $urandom_range(1, 8);
      cl = 42'({$urandom(), $urandom()});
      if ($urandom_range(0, 9) == 0) cl = 42'h3FF_FFFF_FFFF - 42'($urandom_range(0, 8));
      a = {1'($urandom_range(0, 1)), cl, 6'($urandom())};
      gen_data(n);
      model_push(a, n, 0);
      drive_burst(a, n, 0);
      if ($urandom_range(0, 3) == 0) begin
        end_input();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    end_input();
    wait_drain("t6");
    wr_rand = 1'b0;

    // Reset in the middle of a burst: state cleared, partial burst dropped.
    mon_en = 1'b0;
    gen_data(8);
    drive_burst(49'h3000, 2, 0);
    @(negedge clk);
    s_write = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_m_write", m_write, 0);
    check("midrst_idle", idle, 1);
    @(negedge clk);
    reset = 1'b0;
    mon_bib = 0;
    exp_addr_q.delete();
    exp_cnt_q.delete();
    exp_data_q.delete();
    mon_en = 1'b1;
    gen_data(4);
    exp_chunk(49'h1040, 1, 0);
    exp_chunk(49'h1080, 2, 1);
    exp_chunk(49'h1100, 1, 3);
    drive_burst(49'h1040, 4, 0);
    end_input();
    wait_drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
